// File: rtl/filtro_temperatura.sv
// filtro_temperatura: conditions raw temperature sensor samples for the monitor.
// Adds a calibration offset, rejects step glitches once the window is full,
// averages over a 2^LOG2_VENTANA sliding window and clamps to a signed 11-bit range.
// A run of MAX_RECHAZOS consecutive rejections latches a sensor fault until reset.
module filtro_temperatura #(
    parameter int ANCHO_CRUDO  = 12,
    parameter int LOG2_VENTANA = 2,
    parameter int LIMITE_SALTO = 64,
    parameter int MAX_RECHAZOS = 3
) (
    input  logic                   clk,
    input  logic                   rst,
    input  logic                   muestra_valida,
    input  logic [ANCHO_CRUDO-1:0] muestra_cruda,
    input  logic [7:0]             offset_cal,
    output logic [10:0]            temp_entrada,
    output logic                   temp_valida,
    output logic                   falla_sensor,
    output logic [1:0]             estado_filtro
);

    localparam int VENT = 1 << LOG2_VENTANA;
    localparam int W_C  = ANCHO_CRUDO + 1;          // corrected sample width
    localparam int W_S  = W_C + LOG2_VENTANA;       // running sum width
    localparam int W_N  = LOG2_VENTANA + 1;         // fill counter width
    localparam int W_R  = $clog2(MAX_RECHAZOS + 1); // rejection counter width

    localparam logic [1:0] LLENANDO = 2'b00;
    localparam logic [1:0] ACTIVO   = 2'b01;
    localparam logic [1:0] FALLA    = 2'b10;

    localparam logic signed [W_C-1:0] SAT_MAX = W_C'(1023);
    localparam logic signed [W_C-1:0] SAT_MIN = -W_C'(1024);

    // Registered state
    logic [1:0]            estado_q, estado_d;
    logic [W_N-1:0]        cnt_q, cnt_d;
    logic [W_R-1:0]        rech_q, rech_d;
    logic signed [W_C-1:0] ultima_q;
    logic signed [W_C-1:0] ventana_q [VENT];
    logic signed [W_S-1:0] suma_q, suma_d;
    logic                  pend_q;
    logic [10:0]           temp_q;
    logic                  valida_q;

    // Corrected sample; one extra bit makes the addition overflow-free
    logic signed [W_C-1:0] corr;
    assign corr = $signed({muestra_cruda[ANCHO_CRUDO-1], muestra_cruda})
                + $signed({{(W_C-8){offset_cal[7]}}, offset_cal});

    // Step magnitude against the last accepted sample
    logic signed [W_C:0] dif;
    logic        [W_C:0] mag;
    logic                dentro;
    assign dif    = $signed({corr[W_C-1], corr}) - $signed({ultima_q[W_C-1], ultima_q});
    assign mag    = dif[W_C] ? (~dif + 1'b1) : dif;
    assign dentro = (mag <= (W_C+1)'(LIMITE_SALTO));

    logic acepta, rechaza, sale, ultimo_llenado, ultimo_rechazo;
    assign ultimo_llenado = (cnt_q == W_N'(VENT - 1));
    assign ultimo_rechazo = (rech_q == W_R'(MAX_RECHAZOS - 1));
    assign acepta  = muestra_valida && ((estado_q == LLENANDO) || ((estado_q == ACTIVO) && dentro));
    assign rechaza = muestra_valida && (estado_q == ACTIVO) && !dentro;
    assign sale    = acepta && ((estado_q == ACTIVO) || ultimo_llenado);

    // Next-state, counter and running-sum logic
    always_comb begin
        estado_d = estado_q;
        cnt_d    = cnt_q;
        rech_d   = rech_q;
        suma_d   = suma_q;
        if (acepta) begin
            // Oldest entry is still zero while filling, so one formula covers both states
            suma_d = suma_q
                   + $signed({{LOG2_VENTANA{corr[W_C-1]}}, corr})
                   - $signed({{LOG2_VENTANA{ventana_q[VENT-1][W_C-1]}}, ventana_q[VENT-1]});
            rech_d = '0;
            if (estado_q == LLENANDO) begin
                cnt_d = cnt_q + 1'b1;
                if (ultimo_llenado)
                    estado_d = ACTIVO;
            end
        end else if (rechaza) begin
            rech_d = rech_q + 1'b1;
            if (ultimo_rechazo)
                estado_d = FALLA;
        end
    end

    // Decision stage: window shift, sum, counters and FSM
    always_ff @(posedge clk) begin
        if (rst) begin
            estado_q <= LLENANDO;
            cnt_q    <= '0;
            rech_q   <= '0;
            ultima_q <= '0;
            suma_q   <= '0;
            pend_q   <= 1'b0;
            for (int i = 0; i < VENT; i++)
                ventana_q[i] <= '0;
        end else begin
            estado_q <= estado_d;
            cnt_q    <= cnt_d;
            rech_q   <= rech_d;
            suma_q   <= suma_d;
            pend_q   <= sale;
            if (acepta) begin
                ultima_q     <= corr;
                ventana_q[0] <= corr;
                for (int i = 1; i < VENT; i++)
                    ventana_q[i] <= ventana_q[i-1];
            end
        end
    end

    // Average is the sum with its low bits dropped: a floor division by the window size
    logic signed [W_C-1:0] media;
    logic [10:0]           saturada;
    assign media = suma_q[W_S-1:LOG2_VENTANA];

    // Clamp the average to the monitor's input range
    always_comb begin
        saturada = media[10:0];
        if (media > SAT_MAX)
            saturada = SAT_MAX[10:0];
        else if (media < SAT_MIN)
            saturada = SAT_MIN[10:0];
    end

    // Output stage: registers the average one edge after the accepting sample
    always_ff @(posedge clk) begin
        if (rst) begin
            temp_q   <= '0;
            valida_q <= 1'b0;
        end else begin
            valida_q <= pend_q;
            if (pend_q)
                temp_q <= saturada;
        end
    end

    assign temp_entrada  = temp_q;
    assign temp_valida   = valida_q;
    assign falla_sensor  = (estado_q == FALLA);
    assign estado_filtro = estado_q;

endmodule

// File: tb/tb_filtro_temperatura.sv
// Scoreboard bench for filtro_temperatura: stimulus pushes expected outputs,
// a negedge monitor pops and compares on every temp_valida pulse.
module tb_filtro_temperatura;

    logic               clk = 1'b0;
    logic               rst = 1'b1;
    logic               muestra_valida = 1'b0;
    logic signed [11:0] muestra_cruda = '0;
    logic        [7:0]  offset_cal = '0;
    logic signed [10:0] temp_entrada;
    logic               temp_valida;
    logic               falla_sensor;
    logic [1:0]         estado_filtro;

    int n_cmp = 0;
    int n_err = 0;
    int esperados [$];

    filtro_temperatura dut (
        .clk            (clk),
        .rst            (rst),
        .muestra_valida (muestra_valida),
        .muestra_cruda  (muestra_cruda),
        .offset_cal     (offset_cal),
        .temp_entrada   (temp_entrada),
        .temp_valida    (temp_valida),
        .falla_sensor   (falla_sensor),
        .estado_filtro  (estado_filtro)
    );

    always #5 clk = ~clk;

    // Monitor: every output pulse must match the head of the scoreboard
    always @(negedge clk) begin
        if (!rst && temp_valida) begin
            n_cmp++;
            if (esperados.size() == 0) begin
                n_err++;
                $display("FAIL unexpected_valid: got temp_entrada=%0d, required no output", temp_entrada);
            end else begin
                int e;
                e = esperados.pop_front();
                if (int'(temp_entrada) != e) begin
                    n_err++;
                    $display("FAIL temp_entrada: got %0d, required %0d", temp_entrada, e);
                end
            end
        end
    end

    task automatic chk(input string nombre, input int act, input int req);
        n_cmp++;
        if (act != req) begin
            n_err++;
            $display("FAIL %s: got %0d, required %0d", nombre, act, req);
        end
    endtask

    // Drive one sample for one edge; optionally record the output it must produce
    task automatic enviar(input int v, input bit sale, input int req);
        @(negedge clk);
        muestra_valida = 1'b1;
        muestra_cruda  = 12'(v);
        if (sale) esperados.push_back(req);
        @(posedge clk);
        #1;
        muestra_valida = 1'b0;
    endtask

    task automatic ocioso(input int n);
        repeat (n) @(negedge clk);
    endtask

    task automatic reiniciar(input bit con_muestra, input int v);
        @(negedge clk);
        rst = 1'b1;
        muestra_valida = con_muestra;
        muestra_cruda  = 12'(v);
        @(negedge clk);
        rst = 1'b0;
        muestra_valida = 1'b0;
    endtask

    task automatic chk_reset(input string nombre);
        chk({nombre, "_temp"},   int'(temp_entrada), 0);
        chk({nombre, "_valida"}, int'(temp_valida), 0);
        chk({nombre, "_falla"},  int'(falla_sensor), 0);
        chk({nombre, "_estado"}, int'(estado_filtro), 0);
    endtask

    initial begin
        // Reset state
        repeat (2) @(negedge clk);
        rst = 1'b0;
        #1;
        chk_reset("reset");

        // Fill and first average: 824/4 = 206
        enviar(200, 0, 0);
        enviar(204, 0, 0);
        enviar(208, 0, 0);
        chk("fill_estado_3", int'(estado_filtro), 0);
        enviar(212, 1, 206);
        chk("fill_estado_4", int'(estado_filtro), 1);
        ocioso(3);
        chk("fill_hold", int'(temp_entrada), 206);

        // Offset: 300 - 10 = 290
        reiniciar(0, 0);
        offset_cal = 8'(-10);
        enviar(300, 0, 0);
        enviar(300, 0, 0);
        enviar(300, 0, 0);
        enviar(300, 1, 290);
        ocioso(3);
        offset_cal = 8'd0;

        // Saturation high and low
        reiniciar(0, 0);
        for (int i = 0; i < 4; i++) enviar(2000, i == 3, 1023);
        ocioso(3);
        reiniciar(0, 0);
        for (int i = 0; i < 4; i++) enviar(-2048, i == 3, -1024);
        ocioso(3);

        // Floor rounding: -7 >>> 2 = -2
        reiniciar(0, 0);
        enviar(-1, 0, 0);
        enviar(-2, 0, 0);
        enviar(-2, 0, 0);
        enviar(-2, 1, -2);
        ocioso(3);

        // Glitch rejection, with back-to-back accepted outputs
        reiniciar(0, 0);
        for (int i = 0; i < 6; i++) enviar(100, i >= 3, 100);
        enviar(300, 0, 0);
        ocioso(3);
        chk("glitch_hold", int'(temp_entrada), 100);
        chk("glitch_estado", int'(estado_filtro), 1);
        enviar(101, 1, 100);
        ocioso(3);

        // Fault: counter was cleared by the 101, so three fresh rejections are needed
        enviar(500, 0, 0);
        enviar(500, 0, 0);
        chk("fault_not_yet", int'(falla_sensor), 0);
        enviar(500, 0, 0);
        chk("fault_flag", int'(falla_sensor), 1);
        chk("fault_estado", int'(estado_filtro), 2);
        enviar(100, 0, 0);
        ocioso(3);
        chk("fault_hold", int'(temp_entrada), 100);
        chk("fault_sticky", int'(falla_sensor), 1);

        // Reset with a simultaneous sample: sample must not count toward the fill
        reiniciar(1, 100);
        #1;
        chk_reset("rst2");
        enviar(400, 0, 0);
        enviar(400, 0, 0);
        enviar(400, 0, 0);
        chk("refill_estado_3", int'(estado_filtro), 0);
        enviar(400, 1, 400);
        chk("refill_estado_4", int'(estado_filtro), 1);
        ocioso(4);

        chk("scoreboard_empty", esperados.size(), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule

// File: doc/filtro_temperatura.md
# filtro_temperatura

Sensor conditioning stage that sits directly upstream of the temperature monitor and produces its signed 11-bit `temp_entrada` input. It takes raw signed sensor samples with a valid strobe and applies a per-board offset correction. It rejects single-sample glitches, averages over a sliding window and saturates the result to the monitor's input range. A persistent glitch stream latches a sensor-fault flag.

## Interface
Parameters:
- `ANCHO_CRUDO`, 12: width of the raw signed sample.
- `LOG2_VENTANA`, 2: log2 of the averaging window (window = 4 samples).
- `LIMITE_SALTO`, 64: maximum accepted |corrected sample − last accepted sample|.
- `MAX_RECHAZOS`, 3: consecutive rejections that trigger the fault state.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `rst` in 1: synchronous, active-high reset.
- `muestra_valida` in 1: raw sample strobe; one sample per cycle it is high.
- `muestra_cruda` in `ANCHO_CRUDO`: signed raw sample.
- `offset_cal` in 8: signed calibration offset, added to every sample.
- `temp_entrada` out 11: signed filtered temperature (feeds the monitor).
- `temp_valida` out 1: one-cycle pulse when `temp_entrada` is updated.
- `falla_sensor` out 1: sticky sensor-fault flag.
- `estado_filtro` out 2: FSM state. The encoding is 00 LLENANDO, 01 ACTIVO and 10 FALLA.

## Operation
- **Correction:** c = `muestra_cruda` + sign-extended `offset_cal`. It is computed at `ANCHO_CRUDO`+1 bits, with no overflow.
- **LLENANDO** (the state after reset):
  - Every valid sample is accepted with no step check.
  - Accepted samples are counted.
  - On the 2^`LOG2_VENTANA`-th accepted sample the block moves to ACTIVO, and that same sample produces the first output.
- **ACTIVO:**
  - A sample is accepted iff |c − ultima_aceptada| ≤ `LIMITE_SALTO`.
  - An accepted sample is pushed into the window, updates ultima_aceptada, clears the rejection counter and produces an output.
  - A rejected sample leaves the window and outputs untouched and increments the rejection counter.
  - When the counter reaches `MAX_RECHAZOS`, the block moves to FALLA.
- **FALLA:**
  - `falla_sensor` = 1.
  - All samples are ignored.
  - `temp_entrada` holds its last value and `temp_valida` stays 0.
  - The only exit is `rst`.
- **Window:**
  - Shift register of 2^`LOG2_VENTANA` corrected samples.
  - A running sum is updated as sum + new − oldest, with width `ANCHO_CRUDO`+1+`LOG2_VENTANA`.
  - During LLENANDO the oldest value is 0, because the register is cleared at reset.
- **Average:** sum arithmetic-shifted right by `LOG2_VENTANA`, which floors toward −∞.
- **Saturation:** the average is clamped to [−1024, 1023] before it drives `temp_entrada`.
- **Reset:** clears the window, sum, counters and ultima_aceptada.
  - Reset values: `temp_entrada`=0, `temp_valida`=0, `falla_sensor`=0, `estado_filtro`=00.
  - `rst` has priority over `muestra_valida` in the same cycle.
  - A reset in the middle of filling restarts the fill from zero samples.

## Timing
- **Edge N:** `muestra_valida` is high at edge N. The accept/reject decision and the window/sum update both happen at edge N.
- **Edge N+1:**
  - `temp_entrada` is registered and `temp_valida` is high for the single cycle after edge N+1.
  - Latency is 2 edges from sample to output.
- **Throughput:** back-to-back samples are supported, one per cycle, with no bubbles. `temp_valida` can therefore be high for consecutive cycles.
- **State changes:**
  - LLENANDO→ACTIVO and ACTIVO→FALLA take effect at the edge that consumes the triggering sample.
  - `falla_sensor` is visible after edge N, where N consumes the `MAX_RECHAZOS`-th rejection.
- **Idle cycles:** no state change; outputs hold and `temp_valida`=0.

## Test plan
- **Fill and first average:** reset, `offset_cal`=0, samples 200, 204, 208, 212 on consecutive cycles.
  - No `temp_valida` before the 4th sample.
  - Then `temp_valida` pulses with `temp_entrada`=206, and `estado_filtro` goes 00→01.
- **Offset:** `offset_cal`=−10, four samples of 300 → `temp_entrada`=290.
- **Saturation:**
  - Four samples of 2000 → 1023.
  - After `rst`, four samples of −2048 → −1024.
- **Floor rounding:** samples −1, −2, −2, −2 (sum −7) → `temp_entrada`=−2.
- **Glitch rejection:** steady 100 in ACTIVO, then 300, then 101.
  - The 300 produces no `temp_valida` and `temp_entrada` stays 100.
  - The 101 is accepted: rejection counter cleared, output (100+100+100+101)>>>2 = 100.
- **Fault and reset:** steady 100, then three samples of 500.
  - `falla_sensor`=1 and `estado_filtro`=10 after the third sample.
  - `temp_entrada` holds 100 and a further sample of 100 is ignored.
  - `rst` for one cycle restores all reset values.
  - Next, sample `muestra_valida` asserted in the same cycle as `rst` → ignored.
